// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with thresholds, error pulses and optional FWFT read
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_rd_accept;
    logic              w_wr_accept;
    // a full FIFO still takes a write when the head is popped in the same cycle
    assign w_rd_accept = bus.rd_en && (r_count != '0);
    assign w_wr_accept = bus.wr_en && ((r_count != CW'(DEPTH)) || w_rd_accept);
    always_ff @(posedge clk) begin
        if (w_wr_accept) r_mem[r_wr_ptr] <= bus.data_in;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_data   <= r_mem[r_rd_ptr];
            end
            r_count     <= r_count + CW'(w_wr_accept) - CW'(w_rd_accept);
            r_overflow  <= bus.wr_en && !w_wr_accept;
            r_underflow <= bus.rd_en && !w_rd_accept;
        end
    end
    assign bus.count        = r_count;
    assign bus.full         = r_count == CW'(DEPTH);
    assign bus.empty        = r_count == '0;
    assign bus.almost_full  = r_count >= CW'(AFULL_TH);
    assign bus.almost_empty = r_count <= CW'(AEMPTY_TH);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.data_out     = FWFT ? r_mem[r_rd_ptr] : r_data;
endmodule
